// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, taken-branch flush and HALT control for a 5-stage core
// Ports: clk/reset (async active-low); ins = ID-stage instruction; ex_mem_read/ex_rd describe the EX
// instruction; br_taken/br_target = EX branch resolution; clr_cnt clears stall_cycles.
// Outputs: stall/stall_pm hold PC and fetched word, pc_mux_sel/jmp_loc redirect fetch, flush_id
// bubbles ID/EX, halted flags HALT, stall_cycles is a saturating count of stalled cycles.
module pipeline_hazard_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        clr_cnt,
  output logic        stall,
  output logic        stall_pm,
  output logic        pc_mux_sel,
  output logic [15:0] jmp_loc,
  output logic        flush_id,
  output logic        halted,
  output logic [15:0] stall_cycles
);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  state_t state_q, state_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic uses_rt, lu, halt_op, run;
  logic unused;
  assign opcode  = ins[31:26];
  assign rs      = ins[25:21];
  assign rt      = ins[20:16];
  assign unused  = ^ins[15:0];
  // rt is only a source operand for R-type, store and beq/bne
  assign uses_rt = opcode == 6'b000000 || opcode == 6'b101011 || opcode == 6'b000100 || opcode == 6'b000101;
  assign lu      = ex_mem_read && ex_rd != 5'd0 && (ex_rd == rs || (uses_rt && ex_rd == rt));
  assign halt_op = opcode == 6'b111111;
  assign run     = state_q == RUN;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == HALT ? HALT :
              state_q == FLUSH ? RUN :
              br_taken ? FLUSH :
              (!lu && halt_op) ? HALT : RUN;
  end
  // Outputs are forced low while reset is held so the pipeline sees no stale control.
  always_comb begin
    pc_mux_sel = reset && run && br_taken;
    stall      = reset && (state_q == HALT || (run && !br_taken && (lu || halt_op)));
    stall_pm   = stall;
    flush_id   = reset && (!run || br_taken || lu || halt_op);
    halted     = reset && state_q == HALT;
    jmp_loc    = pc_mux_sel ? br_target : 16'h0000;
  end
  always_comb begin
    stall_cycles_d = clr_cnt ? 16'h0000 :
                     (stall && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 16'd1 : stall_cycles_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cycles_q <= 16'h0000;
    else stall_cycles_q <= stall_cycles_d;
  end
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: randomized and directed checks against a behavioural model
module tb_pipeline_hazard_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] ins = '0;
  logic ex_mem_read = 1'b0;
  logic [4:0] ex_rd = '0;
  logic br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic clr_cnt = 1'b0;
  logic stall, stall_pm, pc_mux_sel, flush_id, halted;
  logic [15:0] jmp_loc, stall_cycles;
  int vectors = 0;
  int miscompares = 0;
  bit m_halted = 0;
  bit m_flush = 0;
  int m_cnt = 0;
  logic [36:0] obs;
  logic [36:0] exp_v;

  pipeline_hazard_controller dut (
    .clk(clk), .reset(reset), .ins(ins), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .br_taken(br_taken), .br_target(br_target), .clr_cnt(clr_cnt), .stall(stall),
    .stall_pm(stall_pm), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .flush_id(flush_id),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  assign obs = {stall, stall_pm, pc_mux_sel, flush_id, halted, jmp_loc, stall_cycles};

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000000, rs, rt, 16'h0000};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h1234};
  endfunction

  // A load in EX hurts the ID instruction if it reads the loaded register as a source.
  function automatic logic model_lu();
    logic [5:0] op;
    logic reads_rt;
    op = ins[31:26];
    reads_rt = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h05);
    return ex_mem_read && ex_rd != 0 && (ex_rd == ins[25:21] || (reads_rt && ex_rd == ins[20:16]));
  endfunction

  // Expected outputs from the behavioural priority list: reset, halted, flushing, branch, hazard/halt.
  function automatic logic [36:0] expect_vec();
    logic s, p, f, h;
    logic [15:0] j;
    s = 0; p = 0; f = 0; h = 0; j = 16'h0;
    if (!reset) return '0;
    if (m_halted) begin s = 1; f = 1; h = 1; end
    else if (m_flush) f = 1;
    else if (br_taken) begin p = 1; f = 1; j = br_target; end
    else if (model_lu() || ins[31:26] == 6'h3f) begin s = 1; f = 1; end
    return {s, s, p, f, h, j, m_cnt[15:0]};
  endfunction

  task automatic model_reset();
    m_halted = 0; m_flush = 0; m_cnt = 0;
  endtask

  task automatic idle();
    ins = 32'h0000_0000; ex_mem_read = 0; ex_rd = 0; br_taken = 0; br_target = 0; clr_cnt = 0;
  endtask

  // One clock: the model takes the step implied by the inputs in front of this edge.
  task automatic advance();
    logic [36:0] e;
    logic lu_now, halt_now;
    e = expect_vec();
    lu_now = model_lu();
    halt_now = ins[31:26] == 6'h3f;
    @(posedge clk);
    if (reset) begin
      if (clr_cnt) m_cnt = 0;
      else if (e[36] && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!m_halted) begin
        if (m_flush) m_flush = 0;
        else if (br_taken) m_flush = 1;
        else if (!lu_now && halt_now) m_halted = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    ins = rtype(5'd3, 5'd4); ex_mem_read = 1; ex_rd = 5'd3; br_taken = 1; br_target = 16'hBEEF;
    #2;
    vectors++;
    if (obs !== 37'h0) begin miscompares++; $display("FAIL reset_hold: got %h expected %h", obs, 37'h0); end
    advance();
    vectors++;
    if (obs !== 37'h0) begin miscompares++; $display("FAIL reset_edge: got %h expected %h", obs, 37'h0); end
    idle();
    reset = 1;
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_release: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_load_use();
    idle(); clr_cnt = 1; advance(); clr_cnt = 0;
    ex_mem_read = 1; ex_rd = 5'd5; ins = rtype(5'd1, 5'd5);
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || {stall, stall_pm, flush_id} !== 3'b111) begin
      miscompares++; $display("FAIL load_use_stall: got %h expected %h", obs, exp_v);
    end
    advance();
    idle();
    #2;
    vectors++;
    if (stall_cycles !== 16'd1 || stall !== 1'b0) begin
      miscompares++; $display("FAIL load_use_count: got cnt=%0d stall=%b expected cnt=1 stall=0", stall_cycles, stall);
    end
    ex_mem_read = 1; ex_rd = 5'd0; ins = rtype(5'd0, 5'd0);
    #1;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || stall !== 1'b0) begin miscompares++; $display("FAIL load_use_r0: got %h expected %h", obs, exp_v); end
    advance();
  endtask

  task automatic test_branch();
    idle(); br_taken = 1; br_target = 16'h0040;
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || jmp_loc !== 16'h0040 || pc_mux_sel !== 1'b1) begin
      miscompares++; $display("FAIL branch_redirect: got %h expected %h", obs, exp_v);
    end
    advance();
    br_taken = 1; br_target = 16'h0099; ex_mem_read = 1; ex_rd = 5'd2; ins = rtype(5'd2, 5'd2);
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || flush_id !== 1'b1 || stall !== 1'b0) begin
      miscompares++; $display("FAIL branch_flush2: got %h expected %h", obs, exp_v);
    end
    advance();
    idle();
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || flush_id !== 1'b0) begin miscompares++; $display("FAIL branch_done: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_simultaneous();
    idle(); br_taken = 1; br_target = 16'h1234; ex_mem_read = 1; ex_rd = 5'd7; ins = rtype(5'd7, 5'd1);
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || stall !== 1'b0) begin miscompares++; $display("FAIL branch_over_lu: got %h expected %h", obs, exp_v); end
    advance(); idle(); advance();
    ex_mem_read = 1; ex_rd = 5'd9; ins = itype(6'b001000, 5'd1, 5'd9);
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || stall !== 1'b0) begin miscompares++; $display("FAIL itype_rt_no_stall: got %h expected %h", obs, exp_v); end
    advance();
  endtask

  task automatic test_halt();
    idle(); ins = 32'hFC00_0000;
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL halt_detect: got %h expected %h", obs, exp_v); end
    advance();
    for (int i = 0; i < 6; i++) begin
      ins = $urandom; br_taken = (i % 2) == 0; br_target = 16'(i * 3 + 1); ex_mem_read = $urandom_range(0, 1);
      ex_rd = 5'($urandom_range(0, 31));
      #2;
      exp_v = expect_vec();
      vectors++;
      if (obs !== exp_v || halted !== 1'b1 || stall !== 1'b1) begin
        miscompares++; $display("FAIL halt_hold: got %h expected %h", obs, exp_v);
      end
      advance();
    end
    #1 reset = 0;
    model_reset();
    #1;
    vectors++;
    if (halted !== 1'b0 || obs !== 37'h0) begin miscompares++; $display("FAIL halt_async_reset: got %h expected %h", obs, 37'h0); end
    idle(); reset = 1;
    #1;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL halt_release: got %h expected %h", obs, exp_v); end
    advance();
  endtask

  task automatic test_counter();
    idle(); ex_mem_read = 1; ex_rd = 5'd4; ins = rtype(5'd4, 5'd0);
    for (int i = 0; i < 70000; i++) advance();
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || stall_cycles !== 16'hFFFF) begin
      miscompares++; $display("FAIL counter_saturate: got cnt=%h expected cnt=%h", stall_cycles, exp_v[15:0]);
    end
    clr_cnt = 1;
    advance();
    clr_cnt = 0; idle();
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || stall_cycles !== 16'h0) begin
      miscompares++; $display("FAIL counter_clear: got cnt=%h expected cnt=0000", stall_cycles);
    end
  endtask

  task automatic test_reset_in_flush();
    idle(); br_taken = 1; br_target = 16'h0ABC; ex_mem_read = 1; ex_rd = 5'd6; ins = rtype(5'd6, 5'd6);
    advance();
    br_taken = 0;
    #1 reset = 0;
    model_reset();
    #1;
    vectors++;
    if (obs !== 37'h0) begin miscompares++; $display("FAIL flush_async_reset: got %h expected %h", obs, 37'h0); end
    idle(); reset = 1;
    #1;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || flush_id !== 1'b0) begin miscompares++; $display("FAIL flush_release: got %h expected %h", obs, exp_v); end
    advance();
    #2;
    exp_v = expect_vec();
    vectors++;
    if (obs !== exp_v || flush_id !== 1'b0) begin miscompares++; $display("FAIL flush_after_edge: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h23};
    for (int i = 0; i < 400; i++) begin
      ins = itype($urandom_range(0, 19) == 0 ? 6'h3f : ops[$urandom_range(0, 5)],
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      ins[15:0] = 16'($urandom);
      ex_mem_read = $urandom_range(0, 1); ex_rd = 5'($urandom_range(0, 7));
      br_taken = $urandom_range(0, 5) == 0; br_target = 16'($urandom); clr_cnt = $urandom_range(0, 19) == 0;
      #2;
      exp_v = expect_vec();
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp_v); end
      advance();
      if (m_halted && $urandom_range(0, 3) == 0) begin
        #1 reset = 0;
        model_reset();
        #1;
        vectors++;
        if (obs !== 37'h0) begin miscompares++; $display("FAIL random_reset_%0d: got %h expected %h", i, obs, 37'h0); end
        reset = 1;
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_simultaneous();
    test_halt();
    test_counter();
    test_reset_in_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
